// File: rtl/spi_pwm_reg_ctrl_if.sv
// spi_pwm_reg_ctrl_if: SPI pin inputs and register-bank outputs of the PWM configuration controller
interface spi_pwm_reg_ctrl_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0] duty;
  logic wr_strobe;
  logic frame_err;
  modport master(output sclk, ncs, copi, input en_out, en_pwm, duty, wr_strobe, frame_err);
  modport slave(input sclk, ncs, copi, output en_out, en_pwm, duty, wr_strobe, frame_err);
endinterface

// File: rtl/spi_pwm_reg_ctrl.sv
// spi_pwm_reg_ctrl: oversampled SPI mode-0 write-only register bank for output/PWM enables and duty
module spi_pwm_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS = 16,
  parameter int MAX_ADDR = 4
) (
  input logic clk,
  input logic rst,
  spi_pwm_reg_ctrl_if.slave bus
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_s, ncs_s, copi_s;
  logic sclk_h, ncs_h, pend;
  logic [FRAME_BITS-1:0] frame;
  logic [CW-1:0] cnt;
  logic sclk_rise, ncs_fall, ncs_rise, full, wr_ok;
  logic [6:0] addr;
  logic [7:0] data;
  assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_h;
  assign ncs_fall = ~ncs_s[SYNC_STAGES-1] & ncs_h;
  assign ncs_rise = ncs_s[SYNC_STAGES-1] & ~ncs_h;
  assign full = cnt == CW'(FRAME_BITS);
  assign addr = frame[FRAME_BITS-2 -: 7];
  assign data = frame[7:0];
  assign wr_ok = full && frame[FRAME_BITS-1] && addr <= 7'(MAX_ADDR);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s <= '0;
      ncs_s <= '1;
      copi_s <= '0;
      sclk_h <= 1'b0;
      ncs_h <= 1'b1;
      pend <= 1'b0;
      frame <= '0;
      cnt <= '0;
      state <= IDLE;
      bus.en_out <= '0;
      bus.en_pwm <= '0;
      bus.duty <= '0;
      bus.wr_strobe <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], bus.sclk};
      ncs_s <= {ncs_s[SYNC_STAGES-2:0], bus.ncs};
      copi_s <= {copi_s[SYNC_STAGES-2:0], bus.copi};
      sclk_h <= sclk_s[SYNC_STAGES-1];
      ncs_h <= ncs_s[SYNC_STAGES-1];
      bus.wr_strobe <= 1'b0;
      bus.frame_err <= 1'b0;
      case (state)
        IDLE: if (ncs_fall || pend) begin
          state <= SHIFT;
          frame <= '0;
          cnt <= '0;
          pend <= 1'b0;
        end
        SHIFT: if (ncs_rise) state <= COMMIT;
          else if (sclk_rise && !ncs_s[SYNC_STAGES-1]) begin
            frame <= {frame[FRAME_BITS-2:0], copi_s[SYNC_STAGES-1]};
            cnt <= (cnt == CW'(FRAME_BITS + 1)) ? cnt : cnt + 1'b1;
          end
        COMMIT: begin
          // a new frame may start while this one is still being judged
          state <= IDLE;
          pend <= ncs_fall;
          bus.frame_err <= !full;
          bus.wr_strobe <= wr_ok;
          if (wr_ok)
            case (addr)
              7'd0: bus.en_out[7:0] <= data;
              7'd1: bus.en_out[15:8] <= data;
              7'd2: bus.en_pwm[7:0] <= data;
              7'd3: bus.en_pwm[15:8] <= data;
              7'd4: bus.duty <= data;
              default: ;
            endcase
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_pwm_reg_ctrl.md
Name: spi_pwm_reg_ctrl

Overview:
- SPI-peripheral configuration controller for the onboarding PWM/output datapath.
- Oversamples an external SPI mode-0 bus (SCLK, nCS, COPI) on the system clock and assembles 16-bit write frames.
- Commits valid frames into the register bank that drives output enables, PWM enables and PWM duty cycle.
- Sits between the chip pins (ui_in) and the PWM generator; write-only, no COPI readback.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk/ncs/copi (legal: 2-3)
- FRAME_BITS, 16, bits per SPI frame (1 R/W + 7 address + 8 data)
- MAX_ADDR, 4, highest writable register address; writes above are dropped

Ports:
- clk  in  1  system clock (10 MHz nominal); SCLK must be <= clk/4
- rst  in  1  asynchronous, active-high reset
- sclk  in  1  SPI clock, asynchronous to clk, idle low
- ncs  in  1  SPI chip select, active low, asynchronous
- copi  in  1  SPI data in, MSB first, asynchronous
- en_out  out  16  output enable bits; [7:0]=addr 0x00, [15:8]=addr 0x01
- en_pwm  out  16  PWM-mode select bits; [7:0]=addr 0x02, [15:8]=addr 0x03
- duty  out  8  PWM duty cycle, addr 0x04
- wr_strobe  out  1  one-cycle pulse when a register is written
- frame_err  out  1  one-cycle pulse when a frame is discarded for bad length

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All state clears immediately on rst assertion and is held while rst is high.
- Reset values: en_out=0x0000, en_pwm=0x0000, duty=0x00, wr_strobe=0, frame_err=0, synchronizer flops=idle (sclk 0, ncs 1, copi 0), bit counter=0, FSM=IDLE.
- Synchronizers: each input passes SYNC_STAGES flops. Edges are detected from the last stage against one extra history flop. Sampling is on a synchronized sclk rising edge.
- FSM states and transitions:
  - IDLE -> SHIFT on synchronized ncs falling edge. Shift register and bit counter clear.
  - SHIFT: on each sclk rising edge with ncs low, shift copi into bit 0 (MSB first). Bit counter increments and saturates at FRAME_BITS+1.
  - SHIFT -> COMMIT on synchronized ncs rising edge.
  - COMMIT: evaluate the frame for exactly one clk, then -> IDLE.
- Frame decode: frame[15]=1 means write, frame[14:8]=address, frame[7:0]=data.
- COMMIT rules:
  - count==FRAME_BITS, write bit=1, address<=MAX_ADDR: update the addressed byte on the COMMIT clk edge; wr_strobe=1 for that cycle.
  - count==FRAME_BITS and (write bit=0 or address>MAX_ADDR): no update, no strobe, no error.
  - count!=FRAME_BITS (short, or long/saturated): no update, frame_err=1 for one cycle.
- Latency: registers change exactly SYNC_STAGES+2 clk cycles after the raw ncs rising edge, given setup to clk.
- sclk edges while ncs is high are ignored. An ncs falling edge seen in COMMIT is held and processed on the IDLE cycle, so back-to-back frames separated by 1 SCLK period are not lost.
- Asserting rst mid-frame aborts the frame and clears all registers. The partial frame is never committed after rst releases; the FSM waits for the next ncs falling edge.
- Bytes not addressed keep their values. Registers are persistent across frames.

Test Plan:
- Reset: assert rst for 5 clk mid-frame, release -> all outputs 0, no wr_strobe or frame_err pulse within 20 clk afterwards.
- Write 0x80_F0 (addr 0x00, data 0xF0), then 0x81_CC -> en_out=0xCCF0, two wr_strobe pulses, en_pwm/duty unchanged at 0.
- Write 0x84_80 -> duty=0x80 exactly SYNC_STAGES+2 clk after the ncs rise; then 0x84_FF -> duty=0xFF.
- Write to invalid address 0x85_AA and read frame 0x04_55 -> all registers unchanged, no wr_strobe, no frame_err.
- Short frame (15 bits of 0x82_7F) and long frame (17 bits) -> frame_err pulses once per frame, en_pwm stays 0x0000. A following valid 0x82_7F -> en_pwm=0x007F.
- Back-to-back frames 0x83_01 and 0x82_02 with 1 SCLK period of ncs high between them -> en_pwm=0x0102, two wr_strobe pulses.
